// File: rtl/rr_dec_arbiter_if.sv
// Request/grant bundle between requesting units and the round-robin
// decoder arbiter; master drives requests, slave returns decoder controls.
interface rr_dec_arbiter_if;
    logic [7:0] REQ;
    logic [2:0] SEL;
    logic       G_L;
    logic [7:0] Y_L;
    logic       BUSY;
    logic       PREEMPT;

    modport master (
        output REQ,
        input  SEL, G_L, Y_L, BUSY, PREEMPT
    );

    modport slave (
        input  REQ,
        output SEL, G_L, Y_L, BUSY, PREEMPT
    );
endinterface

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter driving a 3-to-8 decoder (A/B/C + G_L) for 8 requesters,
// with a one-cycle break-before-make gap and optional hold-time preemption.
module rr_dec_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input logic            CLK,
    input logic            RESET,
    rr_dec_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [2:0]       r_sel;
    logic [2:0]       r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gl;
    logic [7:0]       r_yl;
    logic             r_busy;
    logic             r_preempt;

    logic       w_any;
    logic [2:0] w_pick;
    logic       w_own_req;
    logic       w_timeout;

    assign w_any     = |bus.REQ;
    assign w_own_req = bus.REQ[r_sel];
    assign w_timeout = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);

    // Search upward from the slot after the last owner; last owner ranks lowest.
    always_comb begin : pick
        logic       found;
        logic [2:0] idx;
        w_pick = r_last;
        found  = 1'b0;
        idx    = r_last;
        for (int k = 1; k <= 8; k++) begin
            idx = r_last + 3'(k);
            if (!found && bus.REQ[idx]) begin
                w_pick = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_sel     <= 3'd0;
            r_last    <= 3'd7;
            r_cnt     <= '0;
            r_gl      <= 1'b1;
            r_yl      <= 8'hFF;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            unique case (r_state)
                IDLE, GAP: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_sel   <= w_pick;
                        r_last  <= w_pick;
                        r_cnt   <= '0;
                        r_gl    <= 1'b0;
                        r_yl    <= ~(8'd1 << w_pick);
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // A release wins over a coincident timeout: no preempt flag.
                    if (!w_own_req || w_timeout) begin
                        r_state   <= GAP;
                        r_gl      <= 1'b1;
                        r_yl      <= 8'hFF;
                        r_preempt <= w_own_req;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gl    <= 1'b1;
                    r_yl    <= 8'hFF;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SEL     = r_sel;
    assign bus.G_L     = r_gl;
    assign bus.Y_L     = r_yl;
    assign bus.BUSY    = r_busy;
    assign bus.PREEMPT = r_preempt;
endmodule

// File: doc/rr_dec_arbiter.md
Name: rr_dec_arbiter

Overview:
- Round-robin arbiter that shares one decoder-selected resource among 8 requesters.
- Drives the select lines (A/B/C) and active-low enable G of a 3-to-8 decoder, and produces the matching active-low one-hot grant vector.
- Enforces break-before-make between owners and an optional maximum hold time.
- Sits between requesting units and the decoder-enabled shared bus/device.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles per ownership; 0 = unlimited.
- CNT_W, 8, width of hold counter; MAX_HOLD must be < 2**CNT_W.

Ports:
- CLK  input  1  single system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  8  active-high requests; REQ[i] held high for as long as requester i wants the resource.
- SEL  output  3  index of current/last owner; SEL[0]=A, SEL[1]=B, SEL[2]=C to the decoder.
- G_L  output  1  active-low decoder enable; 0 only in GRANT.
- Y_L  output  8  active-low one-hot grant: Y_L[SEL]=0 when G_L=0, else 8'hFF.
- BUSY  output  1  1 in GRANT or GAP.
- PREEMPT  output  1  one-cycle pulse in the first GAP cycle when a grant ended by MAX_HOLD timeout.

Behaviour:
- Reset (RESET=1 sampled at a CLK edge): state=IDLE, SEL=3'd0, G_L=1, Y_L=8'hFF, BUSY=0, PREEMPT=0, last-owner pointer LAST=7, hold counter=0.
  - RESET overrides everything, including mid-GRANT; the grant drops at that edge.
- Outputs derive only from registers; there is no combinational path REQ -> outputs.
- Round-robin pick: search REQ starting at index (LAST+1) mod 8, wrapping upward; the first set bit wins.
  - Winner is written to SEL and LAST.
  - After reset the search starts at 0.
- State machine (IDLE, GRANT, GAP):
  - IDLE: if REQ!=0 at edge -> GRANT with picked owner, hold counter=0; else stay IDLE. Latency is REQ high at edge n -> G_L=0 in cycle after edge n.
  - GRANT: hold counter increments each cycle. Exits to GAP at the edge where either condition holds:
    - REQ[SEL]=0 (normal release), PREEMPT stays 0.
    - MAX_HOLD!=0 and counter==MAX_HOLD-1 with REQ[SEL] still 1 (timeout), PREEMPT=1 for the GAP cycle.
  - GAP (exactly 1 cycle): G_L=1, Y_L=8'hFF, SEL holds the old owner.
    - At the edge ending GAP, run the pick: REQ!=0 -> GRANT with new owner, counter=0; else IDLE.
- Timeout fairness: the preempted owner has lowest priority in the next pick. If it is the only requester it is re-granted after the 1-cycle GAP.
- Holding requesters never see two owners at once: G_L is 1 for at least one full cycle between any two grants, including a re-grant to the same index.
- Requests appearing or dropping for non-owners during GRANT have no effect until the next pick.
- Simultaneous release by the owner and a new request: GAP, then grant to the new requester.
- MAX_HOLD=0: counter is ignored and never causes preemption; counter saturates rather than wrapping.
- SEL is stable while G_L=0.

Test Plan:
- Reset then REQ=8'h00 for 10 cycles -> IDLE, G_L=1, Y_L=8'hFF, SEL=0, BUSY=0 throughout; RESET asserted mid-GRANT -> G_L=1, Y_L=8'hFF at the next cycle.
- REQ=8'h01 at edge n, held 5 cycles, then dropped -> G_L=0, SEL=0, Y_L=8'hFE from cycle n+1 for 5 cycles, then one GAP cycle, then IDLE; PREEMPT stays 0.
- REQ=8'hFF held constantly, MAX_HOLD=4 -> grants SEL=0,1,2,...,7,0 in order, each 4 cycles long, separated by 1-cycle GAPs with PREEMPT=1 in each GAP.
- After owner 5 releases, REQ=8'b0010_0001 -> next grant SEL=0 (wrap from 6 past 7), not 5; then owner 0 releases, REQ=8'b0010_0000 -> SEL=5.
- Only REQ[3] held, MAX_HOLD=3 -> 3 cycles Y_L=8'hF7, GAP with PREEMPT=1, then re-grant SEL=3; pattern repeats.
- MAX_HOLD=0, REQ[2] held 300 cycles while REQ[6] also high -> SEL=2 with no preemption for all 300 cycles; after release, GAP, then SEL=6.
